// File: rtl/pulse_stretcher_pkg.sv
// Purpose : shared definitions for the pulse stretcher slice. It holds the FSM
//           state encoding that the top module and the bench both use.
// Contents: state_e (ST_IDLE / ST_HIGH / ST_GAP). Code 2'd3 is not used and
//           recovers to ST_IDLE.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Purpose : groups the event and status signals of one pulse stretcher.
// Signals : pulse_in  - one-cycle event strobe from the button shaper
//           clear     - synchronous flush of window, queue and overflow
//           level_out - stretched output window
//           busy      - a window or its trailing gap is in progress
//           pending   - queued events that have not been replayed yet
//           overflow  - sticky flag: an event was dropped on a full queue
// Modports: master drives the strobes; slave is the stretcher itself.
interface pulse_stretcher_if #(
  parameter int PEND_W = 2
);
  logic              pulse_in;
  logic              clear;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in, clear,
    input  level_out, busy, pending, overflow
  );

  modport slave (
    input  pulse_in, clear,
    output level_out, busy, pending, overflow
  );
endinterface

// File: rtl/pulse_stretcher_pending_counter.sv
// Purpose : saturating up/down counter that holds the events waiting for a
//           window. It increments on inc_i and decrements on dec_i. When both
//           are high it holds, because one event is queued while another
//           leaves. An increment on a full counter is refused, and ovf_set_o
//           reports that the event was lost.
// Ports   : clk, rst (async, active-low), clr_i (sync flush), inc_i, dec_i,
//           count_o (current depth), ovf_set_o (one-cycle drop indication).
module pulse_stretcher_pending_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] count_o,
  output logic              ovf_set_o
);

  logic [PEND_W-1:0] count_q;
  logic [PEND_W-1:0] count_d;
  logic              full;

  assign full = &count_q;

  // Next-state logic. A lone decrement on an empty counter is ignored, so the
  // counter never wraps even if a caller misbehaves.
  always_comb begin
    count_d   = count_q;
    ovf_set_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      if (full) ovf_set_o = 1'b1;
      else      count_d   = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  // Depth register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Purpose : turns one-cycle event strobes into fixed-width high windows of
//           HIGH_CYCLES clocks. Each window is followed by a low gap of
//           GAP_CYCLES clocks. Events that arrive during a window or a gap are
//           queued (up to 2**PEND_W-1 of them) and replayed in order.
// Ports   : clk            - system clock, rising edge
//           rst            - asynchronous reset, active-low
//           bus (slave)    - pulse_in, clear in; level_out, busy, pending,
//                            overflow out (see pulse_stretcher_if)
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  pulse_stretcher_if.slave   bus
);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              level_q;
  logic              busy_q;
  logic              overflow_q;
  logic [PEND_W-1:0] pendCount;
  logic              pendOvfSet;
  logic              gapExpire;
  logic              pendInc;
  logic              pendDec;

  assign gapExpire = (state_q == ST_GAP) && (cnt_q == '0);

  // At gap expiry with an empty queue, a strobe in that same cycle starts
  // the next window directly. It never enters the queue, so no event can be
  // stranded in IDLE with pending != 0.
  assign pendDec = gapExpire && (pendCount != '0);
  assign pendInc = bus.pulse_in &&
                   ((state_q == ST_HIGH) || (state_q == ST_GAP)) &&
                   !(gapExpire && (pendCount == '0));

  pulse_stretcher_pending_counter #(
    .PEND_W (PEND_W)
  ) u_pend (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.clear),
    .inc_i     (pendInc),
    .dec_i     (pendDec),
    .count_o   (pendCount),
    .ovf_set_o (pendOvfSet)
  );

  // Window FSM with the down-counter. The level and busy outputs are
  // registered with the state, so each one follows the state that was just
  // entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.pulse_in) begin
            state_q <= ST_HIGH;
            cnt_q   <= HIGH_LOAD;
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_q == '0) begin
            state_q <= ST_GAP;
            cnt_q   <= GAP_LOAD;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            if ((pendCount != '0) || bus.pulse_in) begin
              state_q <= ST_HIGH;
              cnt_q   <= HIGH_LOAD;
              level_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flag. Only clear or reset drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            overflow_q <= 1'b0;
    else if (bus.clear)  overflow_q <= 1'b0;
    else if (pendOvfSet) overflow_q <= 1'b1;
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pendCount;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Purpose : bench for pulse_stretcher (HIGH=4, GAP=2, PEND_W=2, 20 ns clock).
//           The reference model works on a list of scheduled window start
//           times. Expected outputs for every edge are queued, and a monitor
//           process checks them against the DUT on the falling edge.
module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int QMAX = 3;

  typedef struct {
    int edgeNo;
    bit level;
    bit busy;
    int pend;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pulse_stretcher_if #(.PEND_W(2)) psIf ();

  pulse_stretcher #(
    .HIGH_CYCLES (H),
    .GAP_CYCLES  (G),
    .PEND_W      (2),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (psIf)
  );

  always #10 clk = ~clk;

  int   testsRun  = 0;
  int   failCount = 0;
  int   edgeCount = 0;
  int   starts[$];
  bit   ovfModel  = 1'b0;
  exp_t sb[$];

  // Compare the DUT outputs against one expected record.
  task automatic checkOutput(input string tag, input exp_t e);
    testsRun++;
    if (psIf.level_out !== e.level) begin
      failCount++;
      $display("[TB] FAIL %s level_out got %0b want %0b", tag, psIf.level_out, e.level);
    end
    testsRun++;
    if (psIf.busy !== e.busy) begin
      failCount++;
      $display("[TB] FAIL %s busy got %0b want %0b", tag, psIf.busy, e.busy);
    end
    testsRun++;
    if ($isunknown(psIf.pending) || int'(psIf.pending) != e.pend) begin
      failCount++;
      $display("[TB] FAIL %s pending got %0d want %0d", tag, psIf.pending, e.pend);
    end
    testsRun++;
    if (psIf.overflow !== e.ovf) begin
      failCount++;
      $display("[TB] FAIL %s overflow got %0b want %0b", tag, psIf.overflow, e.ovf);
    end
  endtask

  // Derive the visible outputs after edge t from the window schedule.
  function automatic exp_t predict(int t);
    exp_t e;
    e.edgeNo = t;
    e.level  = 1'b0;
    e.busy   = 1'b0;
    e.pend   = 0;
    e.ovf    = ovfModel;
    foreach (starts[i]) begin
      if (starts[i] <= t && t < starts[i] + H)     e.level = 1'b1;
      if (starts[i] <= t && t < starts[i] + H + G) e.busy  = 1'b1;
      if (starts[i] > t)                           e.pend++;
    end
    return e;
  endfunction

  // One clock edge of the reference model. A new event starts at once if
  // nothing is scheduled. Otherwise it is scheduled after the last window's
  // gap, unless QMAX events are already waiting. An event that is itself
  // starting at this edge counts as leaving the queue.
  function automatic void modelStep(bit p, bit c);
    int t;
    int nGe;
    bit hit;
    t = edgeCount;
    while (starts.size() > 0 && starts[0] + H + G <= t) starts.delete(0);
    if (c) begin
      starts.delete();
      ovfModel = 1'b0;
    end else if (p) begin
      if (starts.size() == 0) begin
        starts.push_back(t);
      end else begin
        nGe = 0;
        hit = 1'b0;
        foreach (starts[i]) begin
          if (starts[i] >= t) nGe++;
          if (starts[i] == t) hit = 1'b1;
        end
        if (hit || nGe < QMAX) starts.push_back(starts[starts.size()-1] + H + G);
        else                   ovfModel = 1'b1;
      end
    end
    sb.push_back(predict(t));
    edgeCount++;
  endfunction

  function automatic void modelReset();
    starts.delete();
    ovfModel = 1'b0;
    sb.push_back(predict(edgeCount));
    edgeCount++;
  endfunction

  // One clock of stimulus. The caller runs at posedge+1 and returns at
  // posedge+1.
  task automatic applyStimulus(input bit p, input bit c);
    psIf.pulse_in = p;
    psIf.clear    = c;
    @(posedge clk);
    modelStep(p, c);
    #1;
  endtask

  // Assert reset away from the edge and check at once that it acts
  // asynchronously. Then hold it for two edges.
  task automatic doReset();
    exp_t z;
    @(negedge clk);
    #1;
    rst           = 1'b0;
    psIf.pulse_in = 1'b0;
    psIf.clear    = 1'b0;
    #1;
    z = '{edgeNo: -1, level: 1'b0, busy: 1'b0, pend: 0, ovf: 1'b0};
    checkOutput("async_reset", z);
    repeat (2) begin
      @(posedge clk);
      modelReset();
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: checks one expected record on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput($sformatf("edge%0d", e.edgeNo), e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prob;
    psIf.pulse_in = 1'b0;
    psIf.clear    = 1'b0;

    // Reset, then quiet input keeps everything at zero.
    doReset();
    idle(3);

    // Single pulse.
    applyStimulus(1'b1, 1'b0);
    idle(8);

    // Pulses at relative edges 0, 2, 3.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idle(20);

    // One pulse followed by five more while busy: saturation and overflow.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    idle(30);
    applyStimulus(1'b0, 1'b1);
    idle(2);

    // Full queue with a pulse on the gap-expiry edge.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0);
    idle(30);

    // Clear during a window with a pulse in the same cycle.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    idle(4);

    // Reset in the middle of a window.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idle(1);
    doReset();
    idle(2);

    // Randomised traffic with varying pulse density.
    for (int blk = 0; blk < 15; blk++) begin
      prob = int'($urandom_range(60, 2));
      for (int i = 0; i < 200; i++) begin
        applyStimulus(int'($urandom_range(99)) < prob,
                      $urandom_range(299) == 0);
      end
      if (blk % 5 == 4) doReset();
    end

    psIf.pulse_in = 1'b0;
    psIf.clear    = 1'b0;
    @(negedge clk);
    #1;
    testsRun++;
    if (sb.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain got %0d want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
